// File: rtl/ctr_lfsr.sv
// ctr_lfsr: N-bit XNOR-feedback LFSR counter with an optional full 2^N period,
// a programmable terminal state for modulo-M counting, synchronous load, and
// a registered wrap pulse (tc) raised the cycle after an inc-driven move to 0.
`timescale 1ns/1ps

module ctr_lfsr #(
  parameter int N    = 4,
  parameter int FULL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         term_en,
  input  logic [N-1:0] term,
  output logic [N-1:0] out,
  output logic         tc
);

  // Feedback tap set per width; bit k-1 of the mask selects tap k.
  // These are maximal-length XNOR tap sets, so from 0 the register walks
  // every state except all-ones before returning to 0.
  function automatic int tapMaskFor(input int n);
    int m;
    m = 0;
    case (n)
      3:       m = 'h0006;
      4:       m = 'h000C;
      5:       m = 'h0014;
      6:       m = 'h0030;
      7:       m = 'h0060;
      8:       m = 'h00B8;
      9:       m = 'h0110;
      10:      m = 'h0240;
      11:      m = 'h0500;
      12:      m = 'h0829;
      13:      m = 'h100D;
      14:      m = 'h2015;
      15:      m = 'h6000;
      16:      m = 'hD008;
      default: m = 0;
    endcase
    return m;
  endfunction

  localparam int           TapMaskInt = tapMaskFor(N);
  localparam logic [N-1:0] TapBits    = N'(TapMaskInt);
  localparam logic [N-1:0] AllOnes    = '1;
  localparam logic [N-2:0] LowOnes    = '1;

  // Reject unsupported widths and period modes while elaborating, so a bad
  // instantiation never produces a silently wrong counter.
  if ((N < 3) || (N > 16)) begin : g_bad_n
    $error("ctr_lfsr: N must lie in 3..16");
  end
  if ((FULL != 0) && (FULL != 1)) begin : g_bad_full
    $error("ctr_lfsr: FULL must be 0 or 1");
  end

  logic [N-1:0] out_q;
  logic [N-1:0] out_d;
  logic         tc_q;
  logic         tc_d;
  logic         fb;
  logic [N-1:0] shifted;

  // Feedback bit and the plain shifted successor. In full-period mode the
  // extra XOR with "low N-1 bits all ones" splices all-ones in after
  // 0111..1 and lets all-ones continue on to 1111..0.
  always_comb begin
    fb = ~^(out_q & TapBits);
    if (FULL == 1) begin
      fb = fb ^ (out_q[N-2:0] == LowOnes);
    end
    shifted = {out_q[N-2:0], fb};
  end

  // Next state: load beats inc; a terminal match or all-ones lock-up
  // (short-period mode only) forces 0; tc flags any inc-driven move to 0.
  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    if (load) begin
      out_d = load_val;
    end else if (inc) begin
      if (term_en && (out_q == term)) begin
        out_d = '0;
      end else if ((FULL == 0) && (out_q == AllOnes)) begin
        out_d = '0;
      end else begin
        out_d = shifted;
      end
      tc_d = (out_d == '0);
    end
  end

  // State register; reset clears the count and the wrap pulse at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;

endmodule

// File: tb/tb_ctr_lfsr.sv
// tb_ctr_lfsr: directed sequences, load/lock-up cases, randomized traffic
// against a behavioural model, async reset pulse, and a period sweep over
// every legal width in both period modes.
`timescale 1ns/1ps

module tb_ctr_lfsr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       inc;
  logic       load;
  logic [3:0] loadVal;
  logic       termEn;
  logic [3:0] term;
  logic [3:0] outA;
  logic       tcA;
  logic [3:0] outB;
  logic       tcB;

  logic        sweepRstN;
  logic        sweepInc;
  logic        sweepStart;
  logic [27:0] sweepDone;

  int testsRun = 0;
  int failures = 0;

  localparam logic [3:0] SeqA [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB,
                                       4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
  localparam logic [3:0] SeqB [16] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hB,
                                       4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
  localparam logic [3:0] SeqT [7]  = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB};

  // Short-period counter with load and terminal control.
  ctr_lfsr #(.N(4), .FULL(0)) u_dutA (
    .clk(clk), .rst_n(rst_n), .inc(inc), .load(load), .load_val(loadVal),
    .term_en(termEn), .term(term), .out(outA), .tc(tcA)
  );

  // Full-period counter sharing clock, reset and inc.
  ctr_lfsr #(.N(4), .FULL(1)) u_dutB (
    .clk(clk), .rst_n(rst_n), .inc(inc), .load(1'b0), .load_val(4'h0),
    .term_en(1'b0), .term(4'h0), .out(outB), .tc(tcB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit incV, input bit loadV, input logic [3:0] lvV,
                               input bit teV, input logic [3:0] tV);
    inc     = incV;
    load    = loadV;
    loadVal = lvV;
    termEn  = teV;
    term    = tV;
  endtask

  // Reference successor built from the tap lists and the counting rules
  // using integer arithmetic.
  function automatic logic [15:0] modelNext(input int n, input bit full,
                                            input logic [15:0] cur, input bit doInc,
                                            input bit doLoad, input logic [15:0] lv,
                                            input bit tEn, input logic [15:0] tv);
    int taps [4];
    int nt;
    int allOnes;
    int c;
    int fb;
    taps = '{0, 0, 0, 0};
    nt = 0;
    case (n)
      3:  begin taps = '{3, 2, 0, 0};    nt = 2; end
      4:  begin taps = '{4, 3, 0, 0};    nt = 2; end
      5:  begin taps = '{5, 3, 0, 0};    nt = 2; end
      6:  begin taps = '{6, 5, 0, 0};    nt = 2; end
      7:  begin taps = '{7, 6, 0, 0};    nt = 2; end
      8:  begin taps = '{8, 6, 5, 4};    nt = 4; end
      9:  begin taps = '{9, 5, 0, 0};    nt = 2; end
      10: begin taps = '{10, 7, 0, 0};   nt = 2; end
      11: begin taps = '{11, 9, 0, 0};   nt = 2; end
      12: begin taps = '{12, 6, 4, 1};   nt = 4; end
      13: begin taps = '{13, 4, 3, 1};   nt = 4; end
      14: begin taps = '{14, 5, 3, 1};   nt = 4; end
      15: begin taps = '{15, 14, 0, 0};  nt = 2; end
      16: begin taps = '{16, 15, 13, 4}; nt = 4; end
      default: nt = 0;
    endcase
    allOnes = (1 << n) - 1;
    c = int'(cur);
    if (doLoad) return lv;
    if (!doInc) return cur;
    if (tEn && (cur == tv)) return 16'd0;
    if (!full && (c == allOnes)) return 16'd0;
    fb = 1;
    for (int i = 0; i < nt; i++) fb = fb ^ ((c >> (taps[i] - 1)) & 1);
    if (full && ((c & (allOnes >> 1)) == (allOnes >> 1))) fb = fb ^ 1;
    return 16'(((c << 1) | fb) & allOnes);
  endfunction

  // One counter per width and period mode, free-running from reset; each
  // measures its own period and watches for repeated states.
  for (genvar gn = 3; gn <= 16; gn++) begin : g_n
    for (genvar gf = 0; gf <= 1; gf++) begin : g_f
      localparam int NN  = gn;
      localparam int FF  = gf;
      localparam int IDX = (gn - 3) * 2 + gf;
      logic [NN-1:0] sOut;
      logic          sTc;
      bit            seen [1 << NN];
      bit            done = 1'b0;

      ctr_lfsr #(.N(NN), .FULL(FF)) u_dut (
        .clk(clk), .rst_n(sweepRstN), .inc(sweepInc), .load(1'b0), .load_val('0),
        .term_en(1'b0), .term('0), .out(sOut), .tc(sTc)
      );

      assign sweepDone[IDX] = done;

      initial begin
        int          period;
        bit          dup;
        bit          seqOk;
        bit          tcOk;
        logic [15:0] expVal;
        period = 0;
        dup    = 1'b0;
        seqOk  = 1'b1;
        tcOk   = 1'b1;
        expVal = 16'd0;
        foreach (seen[i]) seen[i] = 1'b0;
        wait (sweepStart);
        seen[0] = 1'b1;
        for (int c = 0; c < (1 << NN) + 4; c++) begin
          @(negedge clk);
          period++;
          expVal = modelNext(NN, (FF != 0), expVal, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
          if (16'(sOut) != expVal) seqOk = 1'b0;
          if (sOut == '0) begin
            if (!sTc) tcOk = 1'b0;
            break;
          end
          if (sTc) tcOk = 1'b0;
          if (seen[sOut]) dup = 1'b1;
          seen[sOut] = 1'b1;
        end
        checkOutput($sformatf("sweep period N=%0d FULL=%0d", NN, FF), period,
                    (FF != 0) ? (1 << NN) : ((1 << NN) - 1));
        checkOutput($sformatf("sweep repeat N=%0d FULL=%0d", NN, FF), dup, 0);
        checkOutput($sformatf("sweep model N=%0d FULL=%0d", NN, FF), seqOk, 1);
        checkOutput($sformatf("sweep tc N=%0d FULL=%0d", NN, FF), tcOk, 1);
        done = 1'b1;
      end
    end
  end

  initial begin
    logic [15:0] seenB;
    int          tcCount;
    logic [15:0] curA;
    logic [15:0] curB;
    logic [15:0] nextA;
    logic [15:0] nextB;
    bit          expTcA;
    bit          expTcB;
    bit          rInc;
    bit          rLoad;
    logic [3:0]  rLv;
    bit          rTe;
    logic [3:0]  rTerm;

    rst_n      = 1'b0;
    sweepRstN  = 1'b0;
    sweepInc   = 1'b0;
    sweepStart = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset outA", outA, 0);
    checkOutput("reset tcA", tcA, 0);
    checkOutput("reset outB", outB, 0);
    checkOutput("reset tcB", tcB, 0);

    // Free run from reset: natural 15-state and 16-state sequences.
    rst_n = 1'b1;
    seenB = '0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      checkOutput($sformatf("seqA out k=%0d", k), outA, SeqA[k % 15]);
      checkOutput($sformatf("seqA tc k=%0d", k), tcA, ((k % 15) == 0));
      checkOutput($sformatf("seqB out k=%0d", k), outB, SeqB[k % 16]);
      checkOutput($sformatf("seqB tc k=%0d", k), tcB, ((k % 16) == 0));
      if (k <= 16) seenB[outB] = 1'b1;
    end
    checkOutput("seqB distinct values", $countones(seenB), 16);

    // Terminal state B gives a 7-state modulo sequence.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 4'hB);
    tcCount = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checkOutput($sformatf("term out k=%0d", k), outA, SeqT[k % 7]);
      checkOutput($sformatf("term tc k=%0d", k), tcA, ((k % 7) == 0));
      if (tcA) tcCount++;
    end
    checkOutput("term tc pulses", tcCount, 2);

    // Load of all-ones, lock-up recovery, and load priority over inc.
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("load F out", outA, 4'hF);
    checkOutput("load F tc", tcA, 0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("lockup out", outA, 0);
    checkOutput("lockup tc", tcA, 1);
    applyStimulus(1'b1, 1'b1, 4'h5, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("load+inc out", outA, 4'h5);
    checkOutput("load+inc tc", tcA, 0);
    applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("load 0 out", outA, 0);
    checkOutput("load 0 tc", tcA, 0);
    applyStimulus(1'b0, 1'b1, 4'h9, 1'b0, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    checkOutput("hold out", outA, 4'h9);
    checkOutput("hold tc", tcA, 0);

    // Randomized traffic against the model, with one mid-cycle reset pulse.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    curA  = 16'd0;
    curB  = 16'd0;
    rTe   = 1'b0;
    rTerm = 4'h0;
    for (int i = 0; i < 400; i++) begin
      rInc  = 1'($urandom_range(0, 1));
      rLoad = ($urandom_range(0, 9) == 0);
      rLv   = 4'($urandom);
      if ((i % 50) == 0) begin
        rTe   = 1'($urandom_range(0, 1));
        rTerm = 4'($urandom);
      end
      applyStimulus(rInc, rLoad, rLv, rTe, rTerm);
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset outA", outA, 0);
        checkOutput("async reset tcA", tcA, 0);
        checkOutput("async reset outB", outB, 0);
        checkOutput("async reset tcB", tcB, 0);
        #1 rst_n = 1'b1;
        curA = 16'd0;
        curB = 16'd0;
      end
      nextA  = modelNext(4, 1'b0, curA, rInc, rLoad, 16'(rLv), rTe, 16'(rTerm));
      expTcA = rInc && !rLoad && (nextA == 16'd0);
      nextB  = modelNext(4, 1'b1, curB, rInc, 1'b0, 16'd0, 1'b0, 16'd0);
      expTcB = rInc && (nextB == 16'd0);
      @(negedge clk);
      checkOutput($sformatf("rand outA i=%0d", i), outA, nextA);
      checkOutput($sformatf("rand tcA i=%0d", i), tcA, expTcA);
      checkOutput($sformatf("rand outB i=%0d", i), outB, nextB);
      checkOutput($sformatf("rand tcB i=%0d", i), tcB, expTcB);
      curA = nextA;
      curB = nextB;
    end

    // Period sweep across all widths and both modes.
    sweepRstN  = 1'b1;
    sweepInc   = 1'b1;
    sweepStart = 1'b1;
    for (int c = 0; (c < 70000) && (sweepDone != '1); c++) @(negedge clk);
    checkOutput("sweep completion", sweepDone, 28'hFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
